alu_regfile_pipe: RTL and testbench

- Parametrised, clocked successor to the combinational ALU + register-file pair.
- Holds NUM_REGS registers of WORD_SIZE bits and executes one 3-bit-coded ALU op per accepted request.
- The result goes to a single-entry write-back (WB) stage with valid/ready handshake, operand bypass and a sticky overflow flag.
- Sits between the instruction-issue logic and the datapath's result consumer.

---
 rtl/alu_regfile_pipe.sv | 126 ++++++++++++
 tb/tb_alu_regfile_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_pipe.sv
// Register file plus 3-bit-coded ALU feeding a single-entry write-back stage
// with valid/ready handshake, operand bypass from WB and a sticky overflow flag.
module alu_regfile_pipe #(
   parameter int unsigned              WORD_SIZE = 16,
   parameter int unsigned              NUM_REGS  = 4,
   parameter logic [WORD_SIZE-1:0]     REG_INIT  = WORD_SIZE'(16'h0010),
   localparam int unsigned             ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [2:0]           op_func,
   input  logic [ADDR_W-1:0]    op_rs1,
   input  logic [ADDR_W-1:0]    op_rs2,
   input  logic [ADDR_W-1:0]    op_rd,
   input  logic                 op_wen,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [WORD_SIZE-1:0] res_data,
   output logic                 res_ovf,
   output logic                 ovf_sticky,
   input  logic                 ovf_clear,
   input  logic [ADDR_W-1:0]    dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data
);

   localparam int unsigned MSB = WORD_SIZE - 1;

   logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
   logic                 r_res_valid;
   logic [WORD_SIZE-1:0] r_res_data;
   logic                 r_res_ovf;
   logic                 r_sticky;
   logic [ADDR_W-1:0]    r_wb_rd;
   logic                 r_wb_wen;

   logic                 w_accept;
   logic                 w_retire;
   logic                 w_wb_fwd;
   logic [WORD_SIZE-1:0] w_rf_a;
   logic [WORD_SIZE-1:0] w_rf_b;
   logic [WORD_SIZE-1:0] w_opa;
   logic [WORD_SIZE-1:0] w_opb;
   logic [WORD_SIZE-1:0] w_sum;
   logic [WORD_SIZE-1:0] w_diff;
   logic [WORD_SIZE-1:0] w_alu;
   logic                 w_ovf;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (32'(a) < NUM_REGS);
   endfunction

   assign op_ready   = !r_res_valid || res_ready;
   assign w_accept   = op_valid && op_ready;
   assign w_retire   = r_res_valid && res_ready;
   assign res_valid  = r_res_valid;
   assign res_data   = r_res_data;
   assign res_ovf    = r_res_ovf;
   assign ovf_sticky = r_sticky;

   // Out-of-range addresses read as zero; the bypass only forwards writes that will land.
   always_comb begin
      w_rf_a   = '0;
      w_rf_b   = '0;
      dbg_data = '0;
      if (in_range(op_rs1))   w_rf_a   = r_regs[op_rs1];
      if (in_range(op_rs2))   w_rf_b   = r_regs[op_rs2];
      if (in_range(dbg_addr)) dbg_data = r_regs[dbg_addr];
   end

   assign w_wb_fwd = r_res_valid && r_wb_wen && in_range(r_wb_rd);
   assign w_opa    = (w_wb_fwd && (r_wb_rd == op_rs1)) ? r_res_data : w_rf_a;
   assign w_opb    = (w_wb_fwd && (r_wb_rd == op_rs2)) ? r_res_data : w_rf_b;
   assign w_sum    = w_opa + w_opb;
   assign w_diff   = w_opa - w_opb;

   always_comb begin
      w_alu = '0;
      w_ovf = 1'b0;
      case (op_func)
         3'b000: begin
            w_alu = w_sum;
            w_ovf = (w_opa[MSB] == w_opb[MSB]) && (w_sum[MSB] != w_opa[MSB]);
         end
         3'b001: begin
            w_alu = w_diff;
            w_ovf = (w_opa[MSB] != w_opb[MSB]) && (w_diff[MSB] != w_opa[MSB]);
         end
         3'b010: w_alu = w_opa & w_opb;
         3'b011: w_alu = w_opa | w_opb;
         3'b100: w_alu = w_opa ^ w_opb;
         3'b101: w_alu = ~w_opa;
         3'b110: w_alu = {w_opa[MSB-1:0], 1'b0};
         3'b111: w_alu = {w_opa[MSB], w_opa[MSB:1]};
         default: w_alu = '0;
      endcase
   end

   // Register file, WB stage and sticky flag; retire writes back, accept reloads WB.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= REG_INIT;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_ovf   <= 1'b0;
         r_sticky    <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_wen    <= 1'b0;
      end else begin
         if (w_retire && r_wb_wen && in_range(r_wb_rd)) r_regs[r_wb_rd] <= r_res_data;
         if (w_retire && r_res_ovf)  r_sticky <= 1'b1;
         else if (ovf_clear)         r_sticky <= 1'b0;
         if (w_accept) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_alu;
            r_res_ovf   <= w_ovf;
            r_wb_rd     <= op_rd;
            r_wb_wen    <= op_wen;
         end else if (w_retire) begin
            r_res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: default 4-register instance plus a
// 3-register instance for out-of-range address handling.
module tb_alu_regfile_pipe;

   logic        clk = 1'b0;
   logic        reset_n;
   always #5 clk = ~clk;

   logic        op_valid, op_ready, op_wen, res_valid, res_ready, res_ovf, ovf_sticky, ovf_clear;
   logic [2:0]  op_func;
   logic [1:0]  op_rs1, op_rs2, op_rd, dbg_addr;
   logic [15:0] res_data, dbg_data;

   logic        t3_op_valid, t3_op_ready, t3_op_wen, t3_res_valid, t3_res_ready, t3_res_ovf;
   logic        t3_ovf_sticky, t3_ovf_clear;
   logic [2:0]  t3_op_func;
   logic [1:0]  t3_op_rs1, t3_op_rs2, t3_op_rd, t3_dbg_addr;
   logic [15:0] t3_res_data, t3_dbg_data;

   alu_regfile_pipe u_dut (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_func(op_func), .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rd(op_rd), .op_wen(op_wen),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
      .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   alu_regfile_pipe #(.NUM_REGS(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .op_valid(t3_op_valid), .op_ready(t3_op_ready),
      .op_func(t3_op_func), .op_rs1(t3_op_rs1), .op_rs2(t3_op_rs2), .op_rd(t3_op_rd),
      .op_wen(t3_op_wen), .res_valid(t3_res_valid), .res_ready(t3_res_ready),
      .res_data(t3_res_data), .res_ovf(t3_res_ovf), .ovf_sticky(t3_ovf_sticky),
      .ovf_clear(t3_ovf_clear), .dbg_addr(t3_dbg_addr), .dbg_data(t3_dbg_data)
   );

   typedef struct {
      logic [2:0]  func;
      logic [1:0]  rs1;
      logic [1:0]  rs2;
      logic [1:0]  rd;
      logic        wen;
      logic [15:0] exp_data;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [9];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic dbg_chk(input logic [1:0] a, input logic [15:0] exp);
      dbg_addr = a;
      #1;
      chk($sformatf("dbg_r%0d", a), 32'(dbg_data), 32'(exp));
   endtask

   task automatic dbg3_chk(input logic [1:0] a, input logic [15:0] exp);
      t3_dbg_addr = a;
      #1;
      chk($sformatf("dbg3_r%0d", a), 32'(t3_dbg_data), 32'(exp));
   endtask

   task automatic drive(input logic [2:0] f, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] d, input logic w);
      op_valid = 1'b1; op_func = f; op_rs1 = a; op_rs2 = b; op_rd = d; op_wen = w;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 1'b0; op_valid = 1'b0; t3_op_valid = 1'b0; ovf_clear = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      op_valid = 1'b0; op_func = '0; op_rs1 = '0; op_rs2 = '0; op_rd = '0; op_wen = 1'b0;
      res_ready = 1'b1; ovf_clear = 1'b0; dbg_addr = '0;
      t3_op_valid = 1'b0; t3_op_func = '0; t3_op_rs1 = '0; t3_op_rs2 = '0; t3_op_rd = '0;
      t3_op_wen = 1'b0; t3_res_ready = 1'b1; t3_ovf_clear = 1'b0; t3_dbg_addr = '0;

      //          func    rs1   rs2   rd    wen   data        ovf
      vecs[0] = '{3'b101, 2'd1, 2'd0, 2'd1, 1'b1, 16'hFFEF, 1'b0};
      vecs[1] = '{3'b111, 2'd1, 2'd0, 2'd2, 1'b1, 16'hFFF7, 1'b0};
      vecs[2] = '{3'b001, 2'd0, 2'd2, 2'd3, 1'b1, 16'h0019, 1'b0};
      vecs[3] = '{3'b100, 2'd3, 2'd1, 2'd0, 1'b1, 16'hFFF6, 1'b0};
      vecs[4] = '{3'b010, 2'd0, 2'd3, 2'd0, 1'b0, 16'h0010, 1'b0};
      vecs[5] = '{3'b011, 2'd2, 2'd3, 2'd0, 1'b0, 16'hFFFF, 1'b0};
      vecs[6] = '{3'b110, 2'd3, 2'd0, 2'd3, 1'b0, 16'h0032, 1'b0};
      vecs[7] = '{3'b000, 2'd2, 2'd1, 2'd0, 1'b0, 16'hFFE6, 1'b0};
      vecs[8] = '{3'b001, 2'd1, 2'd3, 2'd0, 1'b0, 16'hFFD6, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_ovf", 32'(res_ovf), 32'd0);
      chk("rst_sticky", 32'(ovf_sticky), 32'd0);
      chk("rst_op_ready", 32'(op_ready), 32'd1);
      for (int a = 0; a < 4; a++) dbg_chk(2'(a), 16'h0010);

      // Table: back-to-back ops, several through the bypass
      res_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(vecs[i].func, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(res_valid), 32'd1);
         chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(vecs[i].exp_data));
         chk($sformatf("vec%0d_ovf", i), 32'(res_ovf), 32'(vecs[i].exp_ovf));
      end
      @(negedge clk); op_valid = 1'b0;
      @(posedge clk); #1;
      chk("table_drain_valid", 32'(res_valid), 32'd0);
      dbg_chk(2'd0, 16'hFFF6);
      dbg_chk(2'd1, 16'hFFEF);
      dbg_chk(2'd2, 16'hFFF7);
      dbg_chk(2'd3, 16'h0019);

      // Dependent ADD chain
      pulse_reset();
      @(negedge clk); drive(3'b000, 2'd1, 2'd2, 2'd0, 1'b1);
      @(posedge clk); #1; chk("chain_add1", 32'(res_data), 32'h0020);
      @(negedge clk); drive(3'b000, 2'd0, 2'd0, 2'd3, 1'b1);
      @(posedge clk); #1; chk("chain_add2_byp", 32'(res_data), 32'h0040);
      @(negedge clk); op_valid = 1'b0;
      @(posedge clk); #1; chk("chain_drain", 32'(res_valid), 32'd0);
      dbg_chk(2'd0, 16'h0020);
      dbg_chk(2'd3, 16'h0040);

      // Backpressure: hold WB for 3 cycles with a second op waiting
      @(negedge clk); res_ready = 1'b0; drive(3'b100, 2'd1, 2'd3, 2'd1, 1'b1);
      @(posedge clk); #1;
      chk("bp_accept_data", 32'(res_data), 32'h0050);
      @(negedge clk); drive(3'b000, 2'd1, 2'd1, 2'd2, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_hold%0d_ready", c), 32'(op_ready), 32'd0);
         chk($sformatf("bp_hold%0d_valid", c), 32'(res_valid), 32'd1);
         chk($sformatf("bp_hold%0d_data", c), 32'(res_data), 32'h0050);
         dbg_chk(2'd1, 16'h0010);
      end
      @(negedge clk); res_ready = 1'b1; #1;
      chk("bp_ready_comb", 32'(op_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp_reload_data", 32'(res_data), 32'h00A0);
      chk("bp_reload_valid", 32'(res_valid), 32'd1);
      dbg_chk(2'd1, 16'h0050);
      @(negedge clk); op_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_drain", 32'(res_valid), 32'd0);
      dbg_chk(2'd2, 16'h00A0);

      // Overflow and sticky flag
      pulse_reset();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); drive(3'b110, 2'd1, 2'd0, 2'd1, 1'b1);
         @(posedge clk);
      end
      #1; chk("shl10", 32'(res_data), 32'h4000);
      @(negedge clk); drive(3'b000, 2'd1, 2'd1, 2'd2, 1'b1);
      @(posedge clk); #1;
      chk("ovf_add_data", 32'(res_data), 32'h8000);
      chk("ovf_add_ovf", 32'(res_ovf), 32'd1);
      chk("ovf_sticky_pre", 32'(ovf_sticky), 32'd0);
      @(negedge clk); drive(3'b001, 2'd2, 2'd0, 2'd3, 1'b0); ovf_clear = 1'b1;
      @(posedge clk); #1;
      chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);
      chk("ovf_sub_data", 32'(res_data), 32'h7FF0);
      chk("ovf_sub_ovf", 32'(res_ovf), 32'd1);
      @(negedge clk); op_valid = 1'b0; ovf_clear = 1'b0;
      @(posedge clk); #1;
      chk("ovf_sticky_hold", 32'(ovf_sticky), 32'd1);
      @(negedge clk); ovf_clear = 1'b1;
      @(posedge clk); #1;
      chk("ovf_cleared", 32'(ovf_sticky), 32'd0);
      @(negedge clk); ovf_clear = 1'b0;
      dbg_chk(2'd1, 16'h4000);
      dbg_chk(2'd2, 16'h8000);

      // Asynchronous reset with a pending WB entry
      pulse_reset();
      @(negedge clk); res_ready = 1'b0; drive(3'b000, 2'd1, 2'd2, 2'd0, 1'b1);
      @(posedge clk); #1;
      chk("mid_valid", 32'(res_valid), 32'd1);
      chk("mid_data", 32'(res_data), 32'h0020);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_data", 32'(res_data), 32'd0);
      @(negedge clk); reset_n = 1'b1; op_valid = 1'b0; res_ready = 1'b1;
      @(posedge clk); #1;
      dbg_chk(2'd0, 16'h0010);

      // NUM_REGS=3: out-of-range write dropped, no bypass, read as zero
      @(negedge clk);
      t3_op_valid = 1'b1; t3_op_func = 3'b000; t3_op_rs1 = 2'd1; t3_op_rs2 = 2'd2;
      t3_op_rd = 2'd3; t3_op_wen = 1'b1;
      @(posedge clk); #1;
      chk("n3_add_data", 32'(t3_res_data), 32'h0020);
      @(negedge clk);
      t3_op_func = 3'b001; t3_op_rs1 = 2'd3; t3_op_rs2 = 2'd1; t3_op_rd = 2'd0; t3_op_wen = 1'b1;
      @(posedge clk); #1;
      chk("n3_sub_data", 32'(t3_res_data), 32'hFFF0);
      chk("n3_sub_ovf", 32'(t3_res_ovf), 32'd0);
      @(negedge clk); t3_op_valid = 1'b0;
      @(posedge clk); #1;
      dbg3_chk(2'd0, 16'hFFF0);
      dbg3_chk(2'd1, 16'h0010);
      dbg3_chk(2'd2, 16'h0010);
      dbg3_chk(2'd3, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
